reverse_order_stream_vector: RTL and testbench

// - Frame-reversing reorder buffer for V parallel lanes; each lane holds BITS-bit samples.
// - Accepts frames of N vectors on a valid/ready input.
// - Emits each frame with its sample order reversed (index N-1 first) on a valid/ready output.
// - Ping-pong banks let frame k+1 be written while frame k drains.
// - Sits after FFT/filter stages that produce reversed-order frames; restores natural order under backpressure.

---
 rtl/rov_pkg.sv | 6 +
 rtl/pingpong_bank_ctrl.sv | 62 ++++++
 rtl/reverse_order_stream_vector.sv | 38 +++
 tb/tb_reverse_order_stream_vector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rov_pkg.sv
// rov_pkg: shared sample type and bank state encoding for the reverse-order stream buffer.
package rov_pkg;
  localparam int SAMPLE_BITS = 8;
  typedef logic [SAMPLE_BITS-1:0] sample_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
endpackage

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: bank states, write/read pointers, handshakes and frame check for two ping-pong banks.
module pingpong_bank_ctrl
  import rov_pkg::*;
#(
  parameter int N  = 10,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [IW-1:0] wr_idx,
  output logic          load,
  output logic          rd_bank,
  output logic [IW-1:0] rd_idx,
  output logic          out_valid,
  output logic          out_last,
  output logic          frame_err
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  bank_state_e st [2];
  logic wr_done, rd_done, avail, slot_free;
  // a bank is released once its index 0 sits in the output register, so the next frame can start writing
  assign in_ready  = st[wr_bank] == EMPTY || st[wr_bank] == FILLING;
  assign wr_en     = in_valid && in_ready;
  assign wr_done   = wr_idx == LAST;
  assign rd_done   = rd_idx == '0;
  assign avail     = st[rd_bank] == FULL || st[rd_bank] == DRAINING;
  assign slot_free = !out_valid || out_ready;
  assign load      = avail && slot_free;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st        <= '{EMPTY, EMPTY};
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= LAST;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) begin
        st[wr_bank] <= wr_done ? FULL : FILLING;
        wr_idx      <= wr_done ? '0 : wr_idx + 1'b1;
        wr_bank     <= wr_bank ^ wr_done;
        frame_err   <= frame_err | (in_last != wr_done);
      end
      if (load) begin
        st[rd_bank] <= rd_done ? EMPTY : DRAINING;
        rd_idx      <= rd_done ? LAST : rd_idx - 1'b1;
        rd_bank     <= rd_bank ^ rd_done;
      end
      if (slot_free) begin
        out_valid <= avail;
        out_last  <= avail && rd_done;
      end
    end
endmodule

// File: rtl/reverse_order_stream_vector.sv
// reverse_order_stream_vector: V-lane frame reverser with ping-pong storage and a registered output stage.
module reverse_order_stream_vector
  import rov_pkg::*;
#(
  parameter int BITS = SAMPLE_BITS,
  parameter int N    = 10,
  parameter int V    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [BITS-1:0] data_in [V],
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [BITS-1:0] data_out [V],
  output logic            frame_err
);
  localparam int IW = $clog2(N);
  logic          wr_en, wr_bank, load, rd_bank;
  logic [IW-1:0] wr_idx, rd_idx;
  pingpong_bank_ctrl #(.N(N), .IW(IW)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready),
    .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .load(load),
    .rd_bank(rd_bank), .rd_idx(rd_idx), .out_valid(out_valid), .out_last(out_last),
    .frame_err(frame_err)
  );
  for (genvar g = 0; g < V; g++) begin : g_lane
    logic [BITS-1:0] mem [2][N];
    always_ff @(posedge clk)
      if (wr_en) mem[wr_bank][wr_idx] <= data_in[g];
    always_ff @(posedge clk)
      if (!rst_n) data_out[g] <= '0;
      else if (load) data_out[g] <= mem[rd_bank][rd_idx];
  end
endmodule

// File: tb/tb_reverse_order_stream_vector.sv
// tb_reverse_order_stream_vector: randomized scenarios checked against a frame-reversal queue model.
module tb_reverse_order_stream_vector;
  localparam int BITS = 8, N = 10, V = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, out_last, frame_err;
  logic [BITS-1:0] data_in [V];
  logic [BITS-1:0] data_out [V];
  int errors = 0, checks = 0;
  logic [16:0] exp_q [$];
  logic [15:0] fb [N];
  int fcnt = 0;
  logic in_f, out_f, ov, ir;
  logic [16:0] got, expv;

  always #5 clk = ~clk;

  reverse_order_stream_vector #(.BITS(BITS), .N(N), .V(V)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .data_out(data_out), .frame_err(frame_err)
  );

  // one clock: sample handshakes before the edge, then advance the model (frames are reversed whole)
  task automatic tick();
    ov    = out_valid;
    ir    = in_ready;
    got   = {out_last, data_out[1], data_out[0]};
    in_f  = rst_n && in_valid && ir;
    out_f = rst_n && ov && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      fcnt = 0;
    end
    expv = 'x;
    if (out_f && exp_q.size() > 0) expv = exp_q.pop_front();
    if (in_f) begin
      fb[fcnt] = {data_in[1], data_in[0]};
      fcnt++;
      if (fcnt == N) begin
        for (int i = N - 1; i >= 0; i--) exp_q.push_back({1'(i == 0), fb[i]});
        fcnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic present(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid   = 1;
    data_in[0] = a;
    data_in[1] = b;
    in_last    = last;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; out_ready = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    data_in[0] = 0; data_in[1] = 0;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if ({data_out[1], data_out[0]} !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0000", {data_out[1], data_out[0]}); end
  endtask

  task automatic test_single();
    int sent = 0, beats = 0, last_t = -100, first_t = -1;
    do_reset();
    out_ready = 1;
    for (int t = 0; t < 60 && beats < N; t++) begin
      if (sent < N) present(8'(sent), 8'(100 + sent), sent == N - 1); else in_valid = 0;
      tick();
      if (in_f) begin sent++; if (sent == N) last_t = t; end
      if (ov && first_t < 0) first_t = t;
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL single_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    in_valid = 0;
    checks++; if (first_t - last_t != 2) begin errors++; $display("FAIL single_latency: got %0d want 2 ticks", first_t - last_t); end
    checks++; if (beats != N) begin errors++; $display("FAIL single_count: got %0d want %0d", beats, N); end
  endtask

  task automatic test_continuous();
    int sent = 0, beats = 0;
    logic [7:0] a = 8'($urandom), b = 8'($urandom);
    do_reset();
    out_ready = 1;
    for (int t = 0; t < 100 && beats < 4 * N; t++) begin
      if (sent < 4 * N) present(a, b, sent % N == N - 1); else in_valid = 0;
      tick();
      if (sent >= N && sent < 4 * N) begin
        checks++; if (!ir) begin errors++; $display("FAIL cont_in_ready: got %b want 1 at sample %0d", ir, sent); end
      end
      if (beats > 0 && beats < 4 * N) begin
        checks++; if (!ov) begin errors++; $display("FAIL cont_gap: got out_valid %b want 1 after beat %0d", ov, beats); end
      end
      if (in_f) begin sent++; a = 8'($urandom); b = 8'($urandom); end
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL cont_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    in_valid = 0;
    checks++; if (beats != 4 * N) begin errors++; $display("FAIL cont_count: got %0d want %0d", beats, 4 * N); end
  endtask

  task automatic test_backpressure();
    int sent = 0, beats = 0;
    logic stalled = 0, saw_full = 0;
    logic [16:0] hold = '0;
    do_reset();
    for (int t = 0; t < 3000 && beats < 5 * N; t++) begin
      if (!in_valid && sent < 5 * N && $urandom_range(0, 99) < 80)
        present(8'($urandom), 8'($urandom), sent % N == N - 1);
      out_ready = $urandom_range(0, 99) < 30;
      tick();
      if (stalled) begin
        checks++; if (!ov || got !== hold) begin errors++; $display("FAIL bp_stall: got %b/%h want 1/%h", ov, got, hold); end
      end
      stalled = ov && !out_ready;
      hold = got;
      checks++;
      if (sent - beats > 2 * N + 1 || (sent - beats == 2 * N + 1 && ir)) begin
        errors++; $display("FAIL bp_occupancy: got %0d held, in_ready %b, want <= %0d", sent - beats, ir, 2 * N + 1);
      end
      if (!ir) saw_full = 1;
      if (in_f) begin sent++; in_valid = 0; end
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    in_valid = 0;
    checks++; if (beats != 5 * N || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d/%0d left want %0d/0", beats, exp_q.size(), 5 * N); end
    checks++; if (!saw_full) begin errors++; $display("FAIL bp_in_ready_low: got never low want low once"); end
  endtask

  task automatic test_frame_err();
    int sent = 0, beats = 0;
    do_reset();
    out_ready = 1;
    for (int t = 0; t < 60 && beats < N; t++) begin
      if (sent < N) present(8'($urandom), 8'($urandom), sent == 5 || sent == N - 1); else in_valid = 0;
      tick();
      if (in_f) begin
        checks++;
        if (frame_err !== (sent >= 5)) begin errors++; $display("FAIL ferr_flag: got %b want %b after sample %0d", frame_err, sent >= 5, sent); end
        sent++;
      end
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL ferr_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    in_valid = 0;
    checks++; if (beats != N || frame_err !== 1'b1) begin errors++; $display("FAIL ferr_end: got %0d/%b want %0d/1", beats, frame_err, N); end
  endtask

  task automatic test_mid_reset();
    int sent = 0, beats = 0;
    do_reset();
    out_ready = 1;
    for (int t = 0; t < 40 && sent < N + 4; t++) begin
      present(8'($urandom), 8'($urandom), sent % N == N - 1);
      tick();
      if (in_f) sent++;
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL mrst_pre_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    rst_n = 0; in_valid = 0;
    tick();
    rst_n = 1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_state: got valid %b ready %b want 0 1", out_valid, in_ready); end
    sent = 0; beats = 0;
    for (int t = 0; t < 60 && beats < N; t++) begin
      if (sent < N) present(8'($urandom), 8'($urandom), sent == N - 1); else in_valid = 0;
      tick();
      if (in_f) sent++;
      if (out_f) begin
        beats++;
        checks++; if (got !== expv) begin errors++; $display("FAIL mrst_beat%0d: got %h want %h", beats, got, expv); end
      end
    end
    in_valid = 0;
    tick();
    tick();
    checks++; if (beats != N || out_valid !== 1'b0) begin errors++; $display("FAIL mrst_count: got %0d/%b want %0d/0", beats, out_valid, N); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_backpressure();
    test_frame_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
